// File: rtl/lab2_mux_sched_pkg.sv
// Shared constants and state encoding for the lab 2 mux scheduler.
// The mux select is fixed at 2 bits, so the requester count is fixed at 4.
package lab2_pkg;

   localparam int N_REQ_DEF       = 4;
   localparam int DATA_W_DEF      = 2;
   localparam int HOLD_CYCLES_DEF = 8;
   localparam int SEL_W           = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/lab2_mux_sched_rr_pick.sv
// Round-robin pick: rotate the request vector so that ptr sits at bit 0,
// find the first set bit, then rotate that index back into requester space.
module rr_pick
   import lab2_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [SEL_W-1:0]   offset;

   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr +: N_REQ];

   always_comb begin
      offset = '0;
      // Descending scan so the lowest rotated position wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) offset = SEL_W'(k);
      end
   end

   assign any = |req;
   // Two-bit addition wraps modulo N_REQ.
   assign idx = ptr + offset;

endmodule

// File: rtl/lab2_mux_sched.sv
// Round-robin scheduler sharing the board 4:1 mux between four requesters,
// with bounded tenure and a one-cycle turnaround bubble between grants.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no grant, waiting for any request
// S_GRANT | one requester owns the mux; tenure counts its cycles
// S_GAP   | one-cycle bus turnaround bubble, pointer already advanced
module lab2_mux_sched
   import lab2_pkg::*;
#(
   parameter int  N_REQ       = N_REQ_DEF,
   parameter int  DATA_W      = DATA_W_DEF,
   parameter int  HOLD_CYCLES = HOLD_CYCLES_DEF,
   localparam int CNT_W       = $clog2(HOLD_CYCLES) + 1
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] data,
   output logic [N_REQ-1:0]        grant,
   output logic [SEL_W-1:0]        sel,
   output logic [DATA_W-1:0]       mux_out,
   output logic                    valid,
   output logic [CNT_W-1:0]        tenure
);

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic             pick_any;
   logic [SEL_W-1:0] pick_idx;
   logic [N_REQ-1:0] pick_onehot;
   logic             holder_req;
   logic             others_req;
   logic             tenure_max;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
   assign holder_req  = req[sel];
   assign others_req  = |(req & ~grant);
   assign tenure_max  = (tenure == CNT_W'(HOLD_CYCLES - 1));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         grant  <= '0;
         sel    <= '0;
         valid  <= 1'b0;
         tenure <= '0;
         ptr    <= '0;
      end else begin
         case (state)
            S_IDLE, S_GAP: begin
               if (pick_any) begin
                  state  <= S_GRANT;
                  grant  <= pick_onehot;
                  sel    <= pick_idx;
                  valid  <= 1'b1;
                  tenure <= '0;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_GRANT: begin
               // Release and preemption share one exit path into the bubble.
               if (!holder_req || (tenure_max && others_req)) begin
                  state  <= S_GAP;
                  grant  <= '0;
                  valid  <= 1'b0;
                  tenure <= '0;
                  ptr    <= sel + SEL_W'(1);
               end else if (!tenure_max) begin
                  tenure <= tenure + CNT_W'(1);
               end
            end
            default: begin
               state  <= S_IDLE;
               grant  <= '0;
               valid  <= 1'b0;
               tenure <= '0;
            end
         endcase
      end
   end

   always_comb begin
      mux_out = '0;
      if (valid) mux_out = data[sel*DATA_W +: DATA_W];
   end

endmodule

// File: tb/tb_lab2_mux_sched.sv
// Directed bench for lab2_mux_sched: reset, single request, full contention,
// lone holder, preemption with pointer wrap and asynchronous reset.
module tb_lab2_mux_sched;
   import lab2_pkg::*;

   logic       clk_sys;
   logic       reset;
   logic [3:0] req;
   logic [7:0] data;
   logic [3:0] grant;
   logic [1:0] sel;
   logic [1:0] mux_out;
   logic       valid;
   logic [3:0] tenure;

   int checks   = 0;
   int failures = 0;

   lab2_mux_sched #(.N_REQ(4), .DATA_W(2), .HOLD_CYCLES(8)) dut (
      .CLOCK_50 (clk_sys),
      .reset    (reset),
      .req      (req),
      .data     (data),
      .grant    (grant),
      .sel      (sel),
      .mux_out  (mux_out),
      .valid    (valid),
      .tenure   (tenure)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b1111;
      data  = {2'd3, 2'd2, 2'd1, 2'd0};

      // Reset held with all requests active.
      tick();
      tick();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_mux", 32'(mux_out), 32'h0);
      chk("rst_tenure", 32'(tenure), 32'h0);

      // Full contention: 0,1,2,3,0, eight cycles each, one gap between.
      reset = 1'b0;
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("rr_grant_g%0d_c%0d", g, c), 32'(grant), 32'(4'b0001 << (g % 4)));
            chk($sformatf("rr_valid_g%0d_c%0d", g, c), 32'(valid), 32'h1);
            chk($sformatf("rr_tenure_g%0d_c%0d", g, c), 32'(tenure), 32'(c));
            chk($sformatf("rr_mux_g%0d_c%0d", g, c), 32'(mux_out), 32'(g % 4));
         end
         tick();
         chk($sformatf("rr_gap_grant_g%0d", g), 32'(grant), 32'h0);
         chk($sformatf("rr_gap_valid_g%0d", g), 32'(valid), 32'h0);
      end

      // Single request on requester 2.
      reset = 1'b1;
      req   = 4'b0000;
      #2;
      reset = 1'b0;
      data  = 8'b00_10_00_00;
      req   = 4'b0100;
      tick();
      chk("single_grant", 32'(grant), 32'h4);
      chk("single_sel", 32'(sel), 32'h2);
      chk("single_valid", 32'(valid), 32'h1);
      chk("single_mux", 32'(mux_out), 32'h2);
      data = 8'b00_01_00_00;
      #1;
      chk("single_mux_comb", 32'(mux_out), 32'h1);
      req = 4'b0000;
      tick();
      chk("single_gap_grant", 32'(grant), 32'h0);
      chk("single_gap_valid", 32'(valid), 32'h0);
      chk("single_gap_sel", 32'(sel), 32'h2);
      chk("single_gap_ptr", 32'(dut.ptr), 32'h3);
      tick();
      chk("single_idle_state", 32'(dut.state), 32'(S_IDLE));
      chk("single_idle_grant", 32'(grant), 32'h0);

      // Lone holder on requester 1 for 20 cycles: no gap, tenure saturates.
      req = 4'b0010;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk($sformatf("lone_grant_c%0d", c), 32'(grant), 32'h2);
         chk($sformatf("lone_valid_c%0d", c), 32'(valid), 32'h1);
         chk($sformatf("lone_tenure_c%0d", c), 32'(tenure), 32'((c < 7) ? c : 7));
      end

      // Hand over to requester 3, then preempt it with requester 0.
      req = 4'b1000;
      tick();
      chk("pre_release_gap", 32'(valid), 32'h0);
      tick();
      chk("pre_grant3", 32'(grant), 32'h8);
      chk("pre_tenure0", 32'(tenure), 32'h0);
      tick();
      tick();
      tick();
      chk("pre_tenure3", 32'(tenure), 32'h3);
      req = 4'b1001;
      for (int c = 4; c < 8; c++) begin
         tick();
         chk($sformatf("pre_hold_c%0d", c), 32'(grant), 32'h8);
         chk($sformatf("pre_tenure_c%0d", c), 32'(tenure), 32'(c));
      end
      tick();
      chk("pre_gap_grant", 32'(grant), 32'h0);
      chk("pre_gap_valid", 32'(valid), 32'h0);
      chk("pre_gap_ptr", 32'(dut.ptr), 32'h0);
      tick();
      chk("pre_grant0", 32'(grant), 32'h1);
      chk("pre_sel0", 32'(sel), 32'h0);

      // Asynchronous reset between edges during a grant.
      data = 8'b00_00_00_11;
      tick();
      chk("async_pre_mux", 32'(mux_out), 32'h3);
      #2;
      reset = 1'b1;
      #1;
      chk("async_grant", 32'(grant), 32'h0);
      chk("async_valid", 32'(valid), 32'h0);
      chk("async_mux", 32'(mux_out), 32'h0);
      chk("async_tenure", 32'(tenure), 32'h0);
      req = 4'b0110;
      #2;
      reset = 1'b0;
      tick();
      chk("async_after_grant", 32'(grant), 32'h2);
      chk("async_after_sel", 32'(sel), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lab2_mux_sched.md
Name: lab2_mux_sched

Overview:
- Round-robin scheduler that shares the board-level 4:1 multiplexer datapath between four requesters.
- Each requester owns one DATA_W-bit slice of the data bus.
- The block grants exactly one requester at a time, drives the mux select, and presents the selected slice on mux_out.
- It sits between the lab top's KEY/SW inputs (requests/data) and LEDR (grant, select, data display).

Parameters:
- N_REQ, 4: number of requesters; fixed at 4 in this lab (select is 2 bits).
- DATA_W, 2: width of each requester's data slice.
- HOLD_CYCLES, 8: maximum tenure in cycles before preemption when another requester is waiting; must be >= 1.

Ports:
- CLOCK_50  in   1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  active-high request per requester; the top inverts the active-low KEY inputs.
- data  in  N_REQ*DATA_W  requester data; slice i is data[i*DATA_W +: DATA_W].
- grant  out  N_REQ  one-hot grant, or all zero.
- sel  out  2  index of the current grantee.
- mux_out  out  DATA_W  selected data slice.
- valid  out  1  high while a grant is active.
- tenure  out  CNT_W  current tenure count; CNT_W = $clog2(HOLD_CYCLES)+1.

Behaviour:
- Reset (async, active-high, one clock, no synchronous reset path):
  - state=IDLE, grant=0, sel=0, valid=0, tenure=0, rr pointer ptr=0.
  - mux_out=0.
  - Asserting reset mid-tenure clears all outputs immediately, without waiting for a clock edge.
- States: IDLE, GRANT, GAP (2-bit encoding).
- Arbitration pick: the first index i with req[i]=1, scanning cyclically ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ).
- IDLE:
  - If req != 0 at a rising edge: go to GRANT, grant=onehot(pick), sel=pick, valid=1, tenure=0.
  - Latency from req sampled high to grant visible is 1 edge.
- GRANT, evaluated at each edge:
  - Release: req[sel]=0 -> go to GAP.
  - Preempt: tenure == HOLD_CYCLES-1 and some other req[j]=1 (j != sel) -> go to GAP.
  - Otherwise stay in GRANT; tenure increments and saturates at HOLD_CYCLES-1.
  - A lone requester therefore holds the grant indefinitely, with no gap.
  - Release and preempt in the same cycle are handled identically (go to GAP).
- On entry to GAP: grant=0, valid=0, tenure=0, ptr=(sel+1) mod N_REQ. sel keeps its last value.
- GAP lasts exactly 1 cycle (a bus-turnaround bubble):
  - If req != 0 at the next edge, go directly to GRANT using the updated ptr.
  - Otherwise go to IDLE.
- mux_out is combinational: valid ? data[sel slice] : 0. Data changes on the grantee's slice propagate the same cycle.
- Requests from non-granted requesters that are dropped before being served have no effect; there is no request latching.
- req bits are assumed already synchronised to CLOCK_50; the block neither debounces nor synchronises them.
- Fairness: with all N_REQ requesting continuously, each requester receives HOLD_CYCLES cycles of grant, followed by 1 GAP cycle, in index order.

Decomposition:
- Shared package/include lab2_pkg:
  - state encoding localparams S_IDLE=0, S_GRANT=1, S_GAP=2.
  - default N_REQ and DATA_W constants.
- Sub-module rr_pick (combinational):
  - inputs: req, ptr.
  - outputs: any, idx[1:0].
  - implementation: rotate req by ptr, take a fixed-priority find-first, rotate the index back.
- The FSM, tenure counter, pointer register and output mux remain in lab2_mux_sched.

Test Plan:
- Reset: assert reset with req=4'b1111 -> grant=0, sel=0, valid=0, mux_out=0, tenure=0 while reset is high.
- Single request: req=4'b0100, data slice2=2'b10 -> after 1 edge, grant=4'b0100, sel=2, valid=1, mux_out=2'b10. Drop req -> next edge grant=0, valid=0 (GAP); following edge, state=IDLE.
- Full contention: req=4'b1111 held from reset -> grants 0,1,2,3,0 in order; each grant lasts 8 cycles, separated by exactly 1 GAP cycle with valid=0.
- Lone holder: req=4'b0010 held 20 cycles -> grant=4'b0010 for all 20 cycles, no gap, tenure saturates at 7.
- Preemption with pointer wrap: req[3] granted, req[0] asserted at tenure=3 -> GAP after the edge where tenure=7, next grant=4'b0001, ptr=0.
- Async reset mid-tenure: pulse reset between clock edges during GRANT -> grant/valid fall immediately. After release, with req=4'b0110, first grant goes to requester 1 (ptr=0).
